// File: rtl/bitstream_serializer_if.sv
// Word handshake plus serial output bundle for bitstream_serializer.
interface bitstream_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             oOUT;
  logic             oVALID;

  modport master (
    output iDATA,
    output iVALID,
    input  oREADY,
    input  oOUT,
    input  oVALID
  );

  modport slave (
    input  iDATA,
    input  iVALID,
    output oREADY,
    output oOUT,
    output oVALID
  );
endinterface

// File: rtl/bitstream_serializer.sv
// MSB-first parallel-to-serial shifter, one bit per clock, valid/ready word input.
// Define BITSTREAM_SERIALIZER_SKID_EN to add a one-word skid register for gapless streaming.
module bitstream_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  bitstream_serializer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] shregQ, shregD;
  logic [CntW-1:0]  cntQ, cntD;
  logic             ready;
  logic             accept;
  logic             lastBit;

`ifdef BITSTREAM_SERIALIZER_SKID_EN
  logic [WIDTH-1:0] skidQ, skidD;
  logic             skidFullQ, skidFullD;

  assign ready = ~skidFullQ;
`else
  assign ready = (stateQ == StIdle);
`endif

  assign accept  = bus.iVALID & ready;
  assign lastBit = (stateQ == StShift) && (cntQ == LastCnt);

  always_comb begin
    stateD = stateQ;
    shregD = shregQ;
    cntD   = cntQ;
`ifdef BITSTREAM_SERIALIZER_SKID_EN
    skidD     = skidQ;
    skidFullD = skidFullQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          stateD = StShift;
          shregD = bus.iDATA;
          cntD   = '0;
        end
      end
      StShift: begin
        // Zero-fill leaves shregQ all-zero once the LSB has gone out, so oOUT idles low.
        shregD = shregQ << 1;
        cntD   = cntQ + CntW'(1);
        if (lastBit) begin
          stateD = StIdle;
          cntD   = '0;
`ifdef BITSTREAM_SERIALIZER_SKID_EN
          if (skidFullQ) begin
            stateD    = StShift;
            shregD    = skidQ;
            skidFullD = 1'b0;
          end else if (accept) begin
            // Word arriving on the LSB edge goes straight to the shifter: no gap.
            stateD = StShift;
            shregD = bus.iDATA;
          end
`endif
        end
`ifdef BITSTREAM_SERIALIZER_SKID_EN
        if (accept && !lastBit) begin
          skidD     = bus.iDATA;
          skidFullD = 1'b1;
        end
`endif
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ <= StIdle;
      shregQ <= '0;
      cntQ   <= '0;
`ifdef BITSTREAM_SERIALIZER_SKID_EN
      skidQ     <= '0;
      skidFullQ <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      shregQ <= shregD;
      cntQ   <= cntD;
`ifdef BITSTREAM_SERIALIZER_SKID_EN
      skidQ     <= skidD;
      skidFullQ <= skidFullD;
`endif
    end
  end

  assign bus.oOUT   = shregQ[WIDTH-1];
  assign bus.oVALID = (stateQ == StShift);
  assign bus.oREADY = ready;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Bench for bitstream_serializer: bit-queue reference model plus directed literal vectors.
module tb_bitstream_serializer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitstream_serializer_if #(.WIDTH(W)) bus ();

  bitstream_serializer #(.WIDTH(W)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending output bits as a plain queue; one bit leaves per cycle.
  bit   pend[$];
  logic mValid;
  logic mOut;
  bit   live = 1'b0;

  function automatic logic modelReady();
`ifdef BITSTREAM_SERIALIZER_SKID_EN
    return pend.size() < int'(W);
`else
    return !mValid;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      mValid = 1'b0;
      mOut   = 1'b0;
      live   = 1'b1;
    end else if (live) begin
      if (bus.iVALID && modelReady())
        for (int i = int'(W) - 1; i >= 0; i--) pend.push_back(bus.iDATA[i]);
      if (pend.size() > 0) begin
        mValid = 1'b1;
        mOut   = pend.pop_front();
      end else begin
        mValid = 1'b0;
        mOut   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_oVALID", 32'(bus.oVALID), 32'(mValid));
      check("model_oOUT", 32'(bus.oOUT), 32'(mOut));
      check("model_oREADY", 32'(bus.oREADY), 32'(modelReady()));
    end
  end

  // Registered 101 detector standing in for the downstream block.
  logic [1:0] dh;
  logic       detPulse;
  always @(posedge clk) begin
    if (rst) begin
      dh       <= 2'b00;
      detPulse <= 1'b0;
    end else begin
      detPulse <= ({dh, bus.oOUT} == 3'b101);
      dh       <= {dh[0], bus.oOUT};
    end
  end

  task automatic capture(input int n, output logic [31:0] v, output logic [31:0] o,
                         output logic [31:0] r);
    v = '0;
    o = '0;
    r = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v[n-1-i] = bus.oVALID;
      o[n-1-i] = bus.oOUT;
      r[n-1-i] = bus.oREADY;
    end
  endtask

  logic [31:0] v, o, r;
  int pulses, pulseAt;

  initial begin
    bus.iDATA  = '0;
    bus.iVALID = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_oVALID", 32'(bus.oVALID), 32'd0);
    check("reset_oOUT", 32'(bus.oOUT), 32'd0);
    check("reset_oREADY", 32'(bus.oREADY), 32'd1);

    // Single A5 word.
    @(negedge clk);
    bus.iDATA  = 8'hA5;
    bus.iVALID = 1'b1;
    @(posedge clk);
    #1 bus.iVALID = 1'b0;
    capture(9, v, o, r);
    check("a5_valid", v, 32'b111111110);
    check("a5_bits", o, 32'b101001010);
`ifdef BITSTREAM_SERIALIZER_SKID_EN
    check("a5_ready", r, 32'b111111111);
`else
    check("a5_ready", r, 32'b000000001);
`endif

    // iVALID held across A5 then 5A.
    @(negedge clk);
    bus.iDATA  = 8'hA5;
    bus.iVALID = 1'b1;
    @(posedge clk);
    #1 bus.iDATA = 8'h5A;
    fork
      capture(17, v, o, r);
      begin
`ifdef BITSTREAM_SERIALIZER_SKID_EN
        repeat (1) @(posedge clk);
`else
        repeat (9) @(posedge clk);
`endif
        #1 bus.iVALID = 1'b0;
      end
    join
`ifdef BITSTREAM_SERIALIZER_SKID_EN
    check("held_valid", v, 32'b11111111111111110);
    check("held_bits", o, 32'b10100101010110100);
    check("held_ready", r, 32'b10000000111111111);
`else
    check("held_valid", v, 32'b11111111011111111);
    check("held_bits", o, 32'b10100101001011010);
    check("held_ready", r, 32'b00000000100000000);
`endif
    repeat (3) @(negedge clk);

    // Reset during the third bit of FF, then a clean 80.
    bus.iDATA  = 8'hFF;
    bus.iVALID = 1'b1;
    @(posedge clk);
    #1 bus.iVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("ff_bit3_out", 32'(bus.oOUT), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_oVALID", 32'(bus.oVALID), 32'd0);
    check("midrst_oOUT", 32'(bus.oOUT), 32'd0);
    check("midrst_oREADY", 32'(bus.oREADY), 32'd1);
    bus.iDATA  = 8'h80;
    bus.iVALID = 1'b1;
    @(posedge clk);
    #1 bus.iVALID = 1'b0;
    capture(9, v, o, r);
    check("w80_valid", v, 32'b111111110);
    check("w80_bits", o, 32'b100000000);

    // iVALID during reset is ignored.
    @(negedge clk);
    rst        = 1'b1;
    bus.iDATA  = 8'hC3;
    bus.iVALID = 1'b1;
    repeat (2) @(posedge clk);
    #1 begin
      rst        = 1'b0;
      bus.iVALID = 1'b0;
    end
    capture(4, v, o, r);
    check("rstvalid_valid", v, 32'd0);
    check("rstvalid_out", o, 32'd0);

    // A0 then 00 through the 101 detector.
    @(negedge clk);
    bus.iDATA  = 8'hA0;
    bus.iVALID = 1'b1;
    @(posedge clk);
    #1 bus.iDATA = 8'h00;
    pulses  = 0;
    pulseAt = -1;
    fork
      for (int i = 1; i <= 22; i++) begin
        @(negedge clk);
        if (detPulse) begin
          pulses++;
          if (pulseAt < 0) pulseAt = i;
        end
      end
      begin
`ifdef BITSTREAM_SERIALIZER_SKID_EN
        repeat (1) @(posedge clk);
`else
        repeat (9) @(posedge clk);
`endif
        #1 bus.iVALID = 1'b0;
      end
    join
    check("det_pulses", 32'(pulses), 32'd1);
    check("det_cycle", 32'(pulseAt), 32'd4);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
